status_queue_writer: RTL



---
 rtl/status_queue_writer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/status_queue_writer.sv
// rtl/status_queue_writer.sv - posts fixed-size status records into a host-memory circular queue
// Define SQ_STATS_EN to count acknowledged records on entries_written (tied to 0 otherwise).
module status_queue_writer #(
  parameter int TAG_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 queue_start,
  input  logic [31:0]          queue_base_addr,
  input  logic [31:0]          queue_size,
  input  logic                 queue_reset,
  input  logic [31:0]          host_head_ptr,
  input  logic [479:0]         status_data,
  input  logic                 status_valid,
  output logic                 status_ready,
  output logic [31:0]          sq_tx_wr_addr,
  output logic [TAG_WIDTH-1:0] sq_tx_wr_tag,
  output logic                 sq_tx_wr_valid,
  output logic [511:0]         sq_tx_data,
  input  logic                 sq_tx_wr_ready,
  input  logic                 sq_rx_wr_valid,
  input  logic [TAG_WIDTH-1:0] sq_rx_wr_tag,
  output logic                 sq_idle,
  output logic [31:0]          entries_written
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [31:0] MAX_OUT = 32'(MAX_OUTSTANDING);

  state_t      state, state_next;
  logic [31:0] base, size, wr_slot, wr_count, seq, outstanding;
  logic        full, start, accept, retire;

  // Completion tags are informational; only the response count matters.
  logic unused_rx_tag;
  assign unused_rx_tag = ^sq_rx_wr_tag;

  assign full   = (wr_count - host_head_ptr) >= size;
  assign start  = (state == IDLE) && queue_start;
  assign accept = status_valid && status_ready;
  assign retire = sq_rx_wr_valid && (outstanding != 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (queue_start) state_next = RUN;
      RUN:     if (queue_reset) state_next = DRAIN;
      DRAIN:   if ((outstanding == 32'd0) && !sq_tx_wr_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sq_idle      = (state == IDLE);
    status_ready = (state == RUN) && !full && (outstanding < MAX_OUT) &&
                   (!sq_tx_wr_valid || sq_tx_wr_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base        <= 32'd0;
      size        <= 32'd0;
      wr_slot     <= 32'd0;
      wr_count    <= 32'd0;
      seq         <= 32'd1;
      outstanding <= 32'd0;
    end else if (start) begin
      base        <= queue_base_addr;
      size        <= queue_size;
      wr_slot     <= 32'd0;
      wr_count    <= 32'd0;
      seq         <= 32'd1;
      outstanding <= 32'd0;
    end else begin
      if (accept) begin
        wr_slot  <= (wr_slot == size - 32'd1) ? 32'd0 : wr_slot + 32'd1;
        wr_count <= wr_count + 32'd1;
        // Sequence never returns to 0 so a written host slot is always non-zero.
        seq      <= (seq == 32'hFFFF_FFFF) ? 32'd1 : seq + 32'd1;
      end
      if (accept && !retire)      outstanding <= outstanding + 32'd1;
      else if (!accept && retire) outstanding <= outstanding - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_tx_wr_valid <= 1'b0;
      sq_tx_wr_addr  <= 32'd0;
      sq_tx_wr_tag   <= '0;
      sq_tx_data     <= 512'd0;
    end else if (accept) begin
      sq_tx_wr_valid <= 1'b1;
      sq_tx_wr_addr  <= base + wr_slot;
      sq_tx_wr_tag   <= wr_count[TAG_WIDTH-1:0];
      sq_tx_data     <= {seq, status_data};
    end else if (sq_tx_wr_ready) begin
      sq_tx_wr_valid <= 1'b0;
    end
  end

`ifdef SQ_STATS_EN
  logic [31:0] ack_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ack_count <= 32'd0;
    else if (start)  ack_count <= 32'd0;
    else if (retire) ack_count <= ack_count + 32'd1;
  end

  assign entries_written = ack_count;
`else
  assign entries_written = 32'd0;
`endif

endmodule
